// File: rtl/serial_adder_ctrl_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial adder.
// The master drives the request side; the slave (the engine) drives status and result.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, sub, cin, op_a, op_b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, sub, cin, op_a, op_b,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full_adder cell processes one operand bit
// pair per clock, LSB first, with the carry held in a register between cycles.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift_a;
    logic [WIDTH-1:0] r_shift_b;
    logic [WIDTH-1:0] r_shift_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_next_sum;

    full_adder u_fa (
        .i_a    (r_shift_a[0]),
        .i_b    (r_shift_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    // The bit computed this cycle enters at the MSB so the final shift leaves the result aligned.
    assign w_next_sum = {w_fa_sum, r_shift_sum[WIDTH-1:1]};

    // Control FSM and datapath registers; subtract is a + ~b + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_shift_a   <= {WIDTH{1'b0}};
            r_shift_b   <= {WIDTH{1'b0}};
            r_shift_sum <= {WIDTH{1'b0}};
            r_carry     <= 1'b0;
            r_cnt       <= {CW{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_sum       <= {WIDTH{1'b0}};
            r_cout      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_shift_a <= bus.op_a;
                        r_shift_b <= bus.sub ? ~bus.op_b : bus.op_b;
                        r_carry   <= bus.sub ? 1'b1 : bus.cin;
                        r_cnt     <= {CW{1'b0}};
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_shift_a   <= {1'b0, r_shift_a[WIDTH-1:1]};
                    r_shift_b   <= {1'b0, r_shift_b[WIDTH-1:1]};
                    r_shift_sum <= w_next_sum;
                    r_carry     <= w_fa_cout;
                    r_cnt       <= r_cnt + CW'(1);
                    // Terminal compare happens before the counter could wrap.
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_sum   <= w_next_sum;
                        r_cout  <= w_fa_cout;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_busy <= 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH = 8: expected {cout,sum} is
// queued when an operation is started and compared when done pulses.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cyc;
    logic [W:0] exp_q[$];

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic c);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b) ? 1'b1 : 1'b0;
        end else begin
            r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        end
        return r;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check_val("sum", {24'd0, bus.sum}, {24'd0, e[W-1:0]});
                check_val("cout", {31'd0, bus.cout}, {31'd0, e[W]});
            end
        end
    end

    // Called on a negedge with the engine idle; returns on the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic c, output int nbusy);
        bus.start = 1'b1; bus.op_a = a; bus.op_b = b; bus.sub = s; bus.cin = c;
        exp_q.push_back(model(a, b, s, c));
        @(negedge clk);
        bus.start = 1'b0; bus.op_a = ~a; bus.op_b = ~b; bus.sub = ~s; bus.cin = ~c;
        nbusy = 0;
        while (bus.busy === 1'b1 && nbusy < 20) begin
            nbusy++;
            @(negedge clk);
        end
        check_val("done_after_busy", {31'd0, bus.done}, 32'd1);
    endtask

    initial begin
        int nb;
        int t1;
        int k;
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0;
        bus.op_a = '0; bus.op_b = '0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("rst_done", {31'd0, bus.done}, 32'd0);
        check_val("rst_sum", {24'd0, bus.sum}, 32'd0);
        check_val("rst_cout", {31'd0, bus.cout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Carry ripple through every bit, with latency and pulse width.
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, nb);
        check_val("busy_cycles", nb, 32'd8);
        @(negedge clk);
        check_val("done_one_cycle", {31'd0, bus.done}, 32'd0);

        run_op(8'h5A, 8'h25, 1'b0, 1'b1, nb);
        @(negedge clk);
        run_op(8'h10, 8'h01, 1'b1, 1'b1, nb);
        @(negedge clk);
        run_op(8'h00, 8'h01, 1'b1, 1'b0, nb);
        @(negedge clk);

        // Start while busy must be ignored.
        bus.start = 1'b1; bus.op_a = 8'h01; bus.op_b = 8'h01; bus.sub = 1'b0; bus.cin = 1'b0;
        exp_q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1; bus.op_a = 8'hAA; bus.op_b = 8'h55;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        while (bus.busy === 1'b1 && k < 20) begin
            k++;
            @(negedge clk);
        end
        check_val("ign_done", {31'd0, bus.done}, 32'd1);
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy === 1'b1) k++;
        end
        check_val("ign_no_rerun", k, 32'd0);
        check_val("ign_sum_hold", {24'd0, bus.sum}, 32'h02);

        // Back-to-back: new start accepted in the done cycle.
        run_op(8'h10, 8'h20, 1'b0, 1'b0, nb);
        t1 = cyc;
        run_op(8'h03, 8'h04, 1'b0, 1'b0, nb);
        check_val("b2b_spacing", cyc - t1, 32'd9);
        check_val("b2b_busy_cycles", nb, 32'd8);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        bus.start = 1'b1; bus.op_a = 8'hFF; bus.op_b = 8'h01; bus.sub = 1'b0; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("arst_busy", {31'd0, bus.busy}, 32'd0);
        check_val("arst_done", {31'd0, bus.done}, 32'd0);
        check_val("arst_sum", {24'd0, bus.sum}, 32'd0);
        check_val("arst_cout", {31'd0, bus.cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy === 1'b1 || bus.done === 1'b1) k++;
        end
        check_val("arst_no_resume", k, 32'd0);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, nb);
        check_val("post_rst_busy_cycles", nb, 32'd8);
        @(negedge clk);

        // A few random operations of both kinds.
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nb);
            @(negedge clk);
        end

        check_val("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add/subtract engine that feeds the team's 1-bit full_adder cell one operand bit pair per clock, LSB first.
- Registers the carry between cycles and assembles the WIDTH-bit result.
- Intended for area-constrained datapaths where a ripple-carry adder of WIDTH cells is too large.
- Control uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request to begin an operation; sampled only while idle
- sub  input  1  0 = add (a + b + cin), 1 = subtract (a - b); captured with start
- cin  input  1  carry-in for add; ignored when sub = 1; captured with start
- op_a  input  WIDTH  first operand; captured with start
- op_b  input  WIDTH  second operand; captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when sum/cout are updated
- sum  output  WIDTH  result register; holds the last completed result
- cout  output  1  carry-out of the MSB (for subtract: 1 = no borrow)

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; busy, done, cout = 0; sum = 0; internal shift registers, carry register and bit counter = 0.
- Reset asserted mid-operation aborts it: no done pulse, and sum/cout are cleared.
- States:
  - IDLE: busy = 0.
  - RUN: busy = 1.
- IDLE -> RUN on a rising edge with start = 1. On that edge (edge E0):
  - Load shift_a = op_a.
  - Load shift_b = op_b when sub = 0, or ~op_b when sub = 1.
  - Load carry_reg = cin when sub = 0, or 1 when sub = 1.
  - Clear counter to 0.
- In RUN, one full_adder instance takes inputs a = shift_a[0], b = shift_b[0], cin = carry_reg. On each rising edge:
  - Shift shift_a and shift_b right by 1.
  - Shift the full_adder sum into the MSB of an internal shift_sum, which shifts right.
  - Load carry_reg = full_adder cout.
  - Increment the counter.
- RUN -> IDLE on the edge where counter == WIDTH-1 (edge E0+WIDTH). On that edge:
  - Load sum = the completed shift_sum, including the bit computed this cycle.
  - Load cout = full_adder cout.
  - Set done = 1.
- Latency: done is high in the single cycle following edge E0+WIDTH. busy is high for exactly WIDTH cycles, from after E0 through E0+WIDTH.
- done is registered and cleared on the next edge unless a new completion occurs.
- sum and cout change only on completion edges or reset. They hold their value during RUN and indefinitely in IDLE.
- start while busy = 1 is ignored. No queuing, and operands/sub/cin are not re-sampled.
- start in the cycle done = 1 (state IDLE) is accepted. Back-to-back operations therefore have no idle gap beyond the done cycle.
- Operand inputs need to be stable only on the accepting edge.
- Arithmetic: the result is modulo 2^WIDTH. No overflow flag; signed overflow is the consumer's concern.
- Counter width is clog2(WIDTH). The counter must not wrap before the final compare; for WIDTH a power of two, terminal value WIDTH-1 is all ones.

Test Plan (WIDTH = 8):
- Add with carry ripple: start with op_a = 0xFF, op_b = 0x01, sub = 0, cin = 0 -> busy high 8 cycles; done pulse 1 cycle; sum = 0x00, cout = 1.
- Add with carry-in: op_a = 0x5A, op_b = 0x25, cin = 1 -> sum = 0x80, cout = 0.
- Subtract: op_a = 0x10, op_b = 0x01, sub = 1, cin = 1 (ignored) -> sum = 0x0F, cout = 1.
- Subtract with borrow: op_a = 0x00, op_b = 0x01, sub = 1 -> sum = 0xFF, cout = 0.
- Start ignored while busy: start 0x01 + 0x01; at cycle 3 of RUN assert start with op_a = 0xAA, op_b = 0x55 -> single done with sum = 0x02; no second operation; sum holds 0x02.
- Back-to-back start: assert start in the done cycle with 0x03 + 0x04 -> second done exactly 9 cycles after the first; sum = 0x07.
- Reset mid-operation: assert rst asynchronously at cycle 4 of RUN -> busy, done, sum, cout = 0 immediately; no done pulse after rst deasserts; the next start completes normally.
